// File: rtl/vga_timing_pkg.sv
// Shared defaults and phase encoding for the VGA timing controller and its
// per-axis phase counters.
package vga_timing_pkg;

  localparam int DEF_HDT = 640;
  localparam int DEF_HFP = 16;
  localparam int DEF_HSP = 96;
  localparam int DEF_HBP = 48;
  localparam int DEF_VDT = 400;
  localparam int DEF_VFP = 12;
  localparam int DEF_VSP = 2;
  localparam int DEF_VBP = 35;
  localparam bit DEF_HSYNC_POL = 1'b0;
  localparam bit DEF_VSYNC_POL = 1'b1;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  function automatic int phase_total(input int act, input int fp, input int sp, input int bp);
    return act + fp + sp + bp;
  endfunction

endpackage

// File: rtl/vga_phase_counter.sv
// One timing axis: wrapping position counter, ACTIVE/FRONT/SYNC/BACK phase
// FSM and registered sync decode. Used once for pixels and once for lines.
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int LEN_ACT  = DEF_HDT,
  parameter int LEN_FP   = DEF_HFP,
  parameter int LEN_SP   = DEF_HSP,
  parameter int LEN_BP   = DEF_HBP,
  parameter int CNT_W    = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active_next,
  output logic             sync
);

  localparam int TOTAL = phase_total(LEN_ACT, LEN_FP, LEN_SP, LEN_BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FP_START = CNT_W'(LEN_ACT);
  localparam logic [CNT_W-1:0] SP_START = CNT_W'(LEN_ACT + LEN_FP);
  localparam logic [CNT_W-1:0] BP_START = CNT_W'(LEN_ACT + LEN_FP + LEN_SP);

  logic [CNT_W-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;
  logic             sync_q, sync_d;

  // The phase moves on the same step that the counter lands on the first
  // index of the next phase, so phase and count always describe one position.
  always_comb begin
    count_d     = count_q;
    phase_d     = phase_q;
    wrap        = step && (count_q == LAST);
    if (clear) begin
      count_d = '0;
      phase_d = ACTIVE;
    end else if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      case (phase_q)
        ACTIVE:  if (count_d == FP_START) phase_d = FRONT;
        FRONT:   if (count_d == SP_START) phase_d = SYNC;
        SYNC:    if (count_d == BP_START) phase_d = BACK;
        BACK:    if (count_d == '0)       phase_d = ACTIVE;
        default: phase_d = ACTIVE;
      endcase
    end
    sync_d      = (phase_d == SYNC) ? SYNC_POL : ~SYNC_POL;
    active_next = (phase_d == ACTIVE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      phase_q <= ACTIVE;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with registered, mutually aligned outputs.
// Optional macro VGA_PIX_DIV2_EN: pixel tick on every second clock.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int HDT       = DEF_HDT,
  parameter int HFP       = DEF_HFP,
  parameter int HSP       = DEF_HSP,
  parameter int HBP       = DEF_HBP,
  parameter int VDT       = DEF_VDT,
  parameter int VFP       = DEF_VFP,
  parameter int VSP       = DEF_VSP,
  parameter int VBP       = DEF_VBP,
  parameter bit HSYNC_POL = DEF_HSYNC_POL,
  parameter bit VSYNC_POL = DEF_VSYNC_POL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] pixelCnt,
  output logic [8:0] lineCnt,
  output logic       hSync,
  output logic       vSync,
  output logic       displayEn,
  output logic       pixTick,
  output logic       frameStart
);

  localparam int HTOTAL = phase_total(HDT, HFP, HSP, HBP);
  localparam int VTOTAL = phase_total(VDT, VFP, VSP, VBP);

  if (HTOTAL > 1024) begin : g_htotal_chk
    $error("vga_timing_ctrl: HTOTAL exceeds 1024");
  end
  if (VTOTAL > 512) begin : g_vtotal_chk
    $error("vga_timing_ctrl: VTOTAL exceeds 512");
  end
  if (HDT == 0 || HFP == 0 || HSP == 0 || HBP == 0 ||
      VDT == 0 || VFP == 0 || VSP == 0 || VBP == 0) begin : g_phase_chk
    $error("vga_timing_ctrl: zero-length timing phase");
  end

  logic tick_en;
  logic h_step, h_wrap, v_wrap;
  logic h_active_next, v_active_next;
  logic running_q, running_d;
  logic pix_tick_q, pix_tick_d;
  logic display_en_q, display_en_d;
  logic frame_start_q, frame_start_d;

`ifdef VGA_PIX_DIV2_EN
  logic div_q, div_d;

  // Divider is parked at 0 while idle so the first tick always lands two
  // clocks after enable (or reset release).
  always_comb begin
    div_d   = enable ? ~div_q : 1'b0;
    tick_en = enable & div_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= 1'b0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  always_comb begin
    tick_en = enable;
  end
`endif

  // The first tick after idle only presents (0,0); counting starts on the next.
  always_comb begin
    h_step        = tick_en & running_q;
    running_d     = enable & (running_q | tick_en);
    pix_tick_d    = tick_en;
    frame_start_d = tick_en & (~running_q | (h_wrap & v_wrap));
    display_en_d  = running_d & h_active_next & v_active_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      running_q     <= 1'b0;
      pix_tick_q    <= 1'b0;
      display_en_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      running_q     <= running_d;
      pix_tick_q    <= pix_tick_d;
      display_en_q  <= display_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  vga_phase_counter #(
    .LEN_ACT  (HDT),
    .LEN_FP   (HFP),
    .LEN_SP   (HSP),
    .LEN_BP   (HBP),
    .CNT_W    (10),
    .SYNC_POL (HSYNC_POL)
  ) u_horiz (
    .clock       (clock),
    .reset       (reset),
    .clear       (~enable),
    .step        (h_step),
    .count       (pixelCnt),
    .wrap        (h_wrap),
    .active_next (h_active_next),
    .sync        (hSync)
  );

  vga_phase_counter #(
    .LEN_ACT  (VDT),
    .LEN_FP   (VFP),
    .LEN_SP   (VSP),
    .LEN_BP   (VBP),
    .CNT_W    (9),
    .SYNC_POL (VSYNC_POL)
  ) u_vert (
    .clock       (clock),
    .reset       (reset),
    .clear       (~enable),
    .step        (h_wrap),
    .count       (lineCnt),
    .wrap        (v_wrap),
    .active_next (v_active_next),
    .sync        (vSync)
  );

  assign displayEn  = display_en_q;
  assign pixTick    = pix_tick_q;
  assign frameStart = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default-timing instance and a small inverted-
// polarity instance checked every clock against a linear raster-position model.
module tb_vga_timing_ctrl;

`ifdef VGA_PIX_DIV2_EN
  localparam int DIVF = 2;
`else
  localparam int DIVF = 1;
`endif

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;

  logic [9:0] a_pix, b_pix;
  logic [8:0] a_line, b_line;
  logic a_hs, a_vs, a_de, a_pt, a_fs;
  logic b_hs, b_vs, b_de, b_pt, b_fs;

  always #5 clock = ~clock;

  vga_timing_ctrl u_a (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pixelCnt   (a_pix),
    .lineCnt    (a_line),
    .hSync      (a_hs),
    .vSync      (a_vs),
    .displayEn  (a_de),
    .pixTick    (a_pt),
    .frameStart (a_fs)
  );

  vga_timing_ctrl #(
    .HDT(20), .HFP(4), .HSP(6), .HBP(6),
    .VDT(8),  .VFP(2), .VSP(3), .VBP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_b (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pixelCnt   (b_pix),
    .lineCnt    (b_line),
    .hSync      (b_hs),
    .vSync      (b_vs),
    .displayEn  (b_de),
    .pixTick    (b_pt),
    .frameStart (b_fs)
  );

  int c_hdt[2] = '{640, 20};
  int c_hfp[2] = '{16, 4};
  int c_hsp[2] = '{96, 6};
  int c_hbp[2] = '{48, 6};
  int c_vdt[2] = '{400, 8};
  int c_vfp[2] = '{12, 2};
  int c_vsp[2] = '{2, 3};
  int c_vbp[2] = '{35, 2};
  bit c_hpol[2] = '{1'b0, 1'b1};
  bit c_vpol[2] = '{1'b1, 1'b0};

  // Model state: position counts pixels since frame origin.
  int m_pos[2];
  bit m_fs[2];
  bit m_run, m_tick, m_div;

  int total;
  int bad;

  function automatic int htot(input int i);
    return c_hdt[i] + c_hfp[i] + c_hsp[i] + c_hbp[i];
  endfunction

  function automatic int frame_len(input int i);
    return htot(i) * (c_vdt[i] + c_vfp[i] + c_vsp[i] + c_vbp[i]);
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_tick = 1'b0;
    m_div  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0;
      m_fs[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (!enable) begin
      model_reset();
    end else begin
      m_tick = (DIVF == 2) ? m_div : 1'b1;
      m_div  = (DIVF == 2) ? !m_div : 1'b0;
      for (int i = 0; i < 2; i++) m_fs[i] = 1'b0;
      if (m_tick) begin
        if (!m_run) begin
          m_run = 1'b1;
          for (int i = 0; i < 2; i++) begin
            m_pos[i] = 0;
            m_fs[i]  = 1'b1;
          end
        end else begin
          for (int i = 0; i < 2; i++) begin
            m_pos[i] = (m_pos[i] + 1) % frame_len(i);
            m_fs[i]  = (m_pos[i] == 0);
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [9:0] pix, input logic [8:0] ln,
                            input logic hs, input logic vs, input logic de,
                            input logic pt, input logic fs);
    int px, lc, hs0, vs0;
    logic hexp, vexp;
    string nm;
    nm  = (i == 0) ? "A" : "B";
    px  = m_pos[i] % htot(i);
    lc  = m_pos[i] / htot(i);
    hs0 = c_hdt[i] + c_hfp[i];
    vs0 = c_vdt[i] + c_vfp[i];
    hexp = (px >= hs0 && px < hs0 + c_hsp[i]) ? c_hpol[i] : !c_hpol[i];
    vexp = (lc >= vs0 && lc < vs0 + c_vsp[i]) ? c_vpol[i] : !c_vpol[i];
    check({nm, ".pixelCnt"}, 32'(pix), 32'(px));
    check({nm, ".lineCnt"}, 32'(ln), 32'(lc));
    check({nm, ".hSync"}, 32'(hs), 32'(hexp));
    check({nm, ".vSync"}, 32'(vs), 32'(vexp));
    check({nm, ".displayEn"}, 32'(de), 32'(m_run && px < c_hdt[i] && lc < c_vdt[i]));
    check({nm, ".pixTick"}, 32'(pt), 32'(m_tick));
    check({nm, ".frameStart"}, 32'(fs), 32'(m_fs[i]));
  endtask

  task automatic check_output();
    check_inst(0, a_pix, a_line, a_hs, a_vs, a_de, a_pt, a_fs);
    check_inst(1, b_pix, b_line, b_hs, b_vs, b_de, b_pt, b_fs);
  endtask

  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_output();
    end
  endtask

  initial begin
    bit found;
    total = 0;
    bad   = 0;
    model_reset();

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1 check_output();

    enable = 1'b1;
    apply_stimulus(3);
    reset = 1'b1;

    // Two default lines, several full frames of the small instance.
    apply_stimulus(1700 * DIVF);

    // Random enable drops and restarts mid-frame.
    for (int k = 0; k < 6; k++) begin
      enable = 1'b1;
      apply_stimulus(int'($urandom_range(3000, 50)));
      enable = 1'b0;
      apply_stimulus(int'($urandom_range(20, 1)));
    end
    enable = 1'b1;

    // Run into B's vsync band, then assert reset between clock edges.
    found = 1'b0;
    for (int n = 0; n < 2000 * DIVF && !found; n++) begin
      apply_stimulus(1);
      if (m_run && (m_pos[1] / htot(1)) >= 10 && (m_pos[1] / htot(1)) <= 12 &&
          (m_pos[1] % htot(1)) > 25)
        found = 1'b1;
    end
    check("B.vsync_reached", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1 model_reset();
    check_output();
    apply_stimulus(4);
    reset = 1'b1;
    apply_stimulus(600 * DIVF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
